breath_key_ctrl: RTL and testbench



---
 rtl/breath_pkg.sv | 27 ++
 rtl/key_filter.sv | 47 ++++
 rtl/breath_key_ctrl.sv | 111 +++++++++++
 tb/tb_breath_key_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED path: mode encodings, key timing
// defaults and the breath timing constants used by the downstream generator.
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_t;

  // Key timing: 20 ms at 50 MHz, and 100 x 20 ms = 2 s for a long press.
  localparam logic [19:0] CNT_20MS_MAX_DEF = 20'd999_999;
  localparam logic [6:0]  HOLD_TICKS_DEF   = 7'd100;

  // Breath generator timing, shared with the downstream PWM stage.
  localparam logic [5:0]  BREATH_CNT_1US_MAX   = 6'd49;
  localparam logic [9:0]  BREATH_CNT_1MS_MAX   = 10'd999;
  localparam logic [9:0]  BREATH_CNT_SLOW_MAX  = 10'd999;
  localparam logic [9:0]  BREATH_CNT_FAST_MAX  = 10'd499;

  // Short-press advance: OFF -> SLOW -> FAST -> ON -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/key_filter.sv
// Two-flop synchroniser plus counter debouncer for an active-low push-button.
// A level change on key_db is accepted only after CNT_MAX+1 consecutive
// cycles on which the synchronised input differs from key_db.
module key_filter
  import breath_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = CNT_20MS_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_db
);

  logic        sync_1;
  logic        key_sync;
  logic [19:0] deb_cnt;

  // Bring the raw button into sys_clk; resets to the released level.
  // NOTE: non-blocking assignments here keep the two flops a true shift
  // register; blocking ones would collapse them into a single stage.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_1   <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      sync_1   <= key_in;
      key_sync <= sync_1;
    end
  end

  // Accept a new level only once it has been stable for the full window.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      deb_cnt <= '0;
      key_db  <= 1'b1;
    end else if (key_sync == key_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_MAX) begin
      deb_cnt <= '0;
      key_db  <= key_sync;
    end else begin
      deb_cnt <= deb_cnt + 20'd1;
    end
  end

endmodule

// File: rtl/breath_key_ctrl.sv
// Key control for the breathing LED: debounced button, press/release edge
// detection, long-press hold timing and the 4-mode selector with its
// decoded outputs.
module breath_key_ctrl
  import breath_pkg::*;
#(
  parameter logic [19:0] CNT_20MS_MAX = CNT_20MS_MAX_DEF,
  parameter logic [6:0]  HOLD_TICKS   = HOLD_TICKS_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_flag,
  output logic       long_flag,
  output logic [1:0] mode,
  output logic       breath_en,
  output logic       breath_fast,
  output logic       led_force_on
);

  logic        key_db;
  logic        key_db_d;
  logic        press_evt;
  logic        release_evt;
  logic [19:0] tick_cnt;
  logic [6:0]  hold_cnt;
  logic        long_done;
  logic        long_hit;
  mode_t       mode_q;
  mode_t       mode_d;

  key_filter #(
    .CNT_MAX (CNT_20MS_MAX)
  ) u_key_filter (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_in  (key_in),
    .key_db  (key_db)
  );

  // Delay the debounced level by one cycle for edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) key_db_d <= 1'b1;
    else         key_db_d <= key_db;
  end

  assign press_evt   =  key_db_d & ~key_db;
  assign release_evt = ~key_db_d &  key_db;

  // The long press fires on the tick wrap that takes hold_cnt to HOLD_TICKS.
  assign long_hit = ~key_db && (tick_cnt == CNT_20MS_MAX) &&
                    (hold_cnt == HOLD_TICKS - 7'd1);

  // Register the press pulse and the long-press pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_flag  <= 1'b0;
      long_flag <= 1'b0;
    end else begin
      key_flag  <= press_evt;
      long_flag <= long_hit;
    end
  end

  // Count 20 ms ticks while the key is held; clear everything on release.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else if (key_db) begin
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      if (tick_cnt == CNT_20MS_MAX) begin
        tick_cnt <= '0;
        if (hold_cnt != HOLD_TICKS) hold_cnt <= hold_cnt + 7'd1;
      end else begin
        tick_cnt <= tick_cnt + 20'd1;
      end
      if (long_hit) long_done <= 1'b1;
    end
  end

  // Mode state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) mode_q <= MODE_OFF;
    else         mode_q <= mode_d;
  end

  // Next mode: long press forces OFF, a short-press release advances.
  // NOTE: mode_d gets a default before any branch so no latch is inferred.
  always_comb begin
    mode_d = mode_q;
    if (long_hit)
      mode_d = MODE_OFF;
    else if (release_evt && !long_done)
      mode_d = next_mode(mode_q);
  end

  // Decode the mode register for the breath generator and LED override.
  always_comb begin
    breath_en    = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
    breath_fast  = (mode_q == MODE_FAST);
    led_force_on = (mode_q == MODE_ON);
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_breath_key_ctrl.sv
// Directed bench for breath_key_ctrl with a 10-cycle debounce window and a
// 4-tick long press.
module tb_breath_key_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_in;
  logic       key_flag;
  logic       long_flag;
  logic [1:0] mode;
  logic       breath_en;
  logic       breath_fast;
  logic       led_force_on;

  int vectors    = 0;
  int miscompares = 0;
  int key_flag_cnt  = 0;
  int long_flag_cnt = 0;

  breath_key_ctrl #(
    .CNT_20MS_MAX (20'd9),
    .HOLD_TICKS   (7'd4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_flag     (key_flag),
    .long_flag    (long_flag),
    .mode         (mode),
    .breath_en    (breath_en),
    .breath_fast  (breath_fast),
    .led_force_on (led_force_on)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge sys_clk) begin
    #2;
    if (key_flag)  key_flag_cnt++;
    if (long_flag) long_flag_cnt++;
  end

  // Advance n rising edges and land on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Apply one press of low_cycles, release, and stop 12 edges after release
  // (one edge before the mode register can move).
  task automatic press_to_release(input int low_cycles);
    key_in = 1'b0;
    edges(low_cycles);
    key_in = 1'b1;
    edges(12);
  endtask

  task automatic test_reset;
    int first;
    int k0;
    sys_rst = 1'b1;
    key_in  = 1'b0;
    edges(3);
    vectors++;
    if (mode !== 2'd0 || key_flag !== 1'b0 || long_flag !== 1'b0) begin
      $display("FAIL reset_state: mode=%0d key_flag=%b long_flag=%b, want 0/0/0",
               mode, key_flag, long_flag);
      miscompares++;
    end
    vectors++;
    if ({breath_en, breath_fast, led_force_on} !== 3'b000) begin
      $display("FAIL reset_decode: got %b want 000", {breath_en, breath_fast, led_force_on});
      miscompares++;
    end
    k0 = key_flag_cnt;
    sys_rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      edges(1);
      if (key_flag && first == 0) first = k;
    end
    vectors++;
    if (first != 13) begin
      $display("FAIL reset_key_flag_latency: got %0d want 13", first);
      miscompares++;
    end
    vectors++;
    if (key_flag_cnt - k0 != 1) begin
      $display("FAIL reset_key_flag_count: got %0d want 1", key_flag_cnt - k0);
      miscompares++;
    end
    // Releasing this press is a normal short press: OFF -> SLOW.
    key_in = 1'b1;
    edges(13);
    vectors++;
    if (mode !== 2'd1) begin
      $display("FAIL reset_release_mode: got %0d want 1", mode);
      miscompares++;
    end
    // Return to a clean OFF state with the key released.
    sys_rst = 1'b1;
    edges(2);
    sys_rst = 1'b0;
    edges(5);
  endtask

  task automatic test_bounce;
    int k0;
    k0 = key_flag_cnt;
    for (int r = 0; r < 4; r++) begin
      key_in = 1'b0;
      edges(5);
      key_in = 1'b1;
      edges(3);
    end
    edges(30);
    vectors++;
    if (key_flag_cnt != k0) begin
      $display("FAIL bounce_key_flag: got %0d pulses want 0", key_flag_cnt - k0);
      miscompares++;
    end
    vectors++;
    if (mode !== 2'd0) begin
      $display("FAIL bounce_mode: got %0d want 0", mode);
      miscompares++;
    end
  endtask

  task automatic test_short_press;
    logic [1:0] exp_mode [4];
    logic [2:0] exp_dec  [4];
    int k0;
    exp_mode[0] = 2'd1; exp_dec[0] = 3'b100;
    exp_mode[1] = 2'd2; exp_dec[1] = 3'b110;
    exp_mode[2] = 2'd3; exp_dec[2] = 3'b001;
    exp_mode[3] = 2'd0; exp_dec[3] = 3'b000;
    for (int p = 0; p < 4; p++) begin
      k0 = key_flag_cnt;
      press_to_release(30);
      vectors++;
      if (mode !== (p == 0 ? 2'd0 : exp_mode[p-1])) begin
        $display("FAIL short_mode_early[%0d]: got %0d want %0d", p, mode,
                 (p == 0 ? 2'd0 : exp_mode[p-1]));
        miscompares++;
      end
      edges(1);
      vectors++;
      if (mode !== exp_mode[p]) begin
        $display("FAIL short_mode[%0d]: got %0d want %0d", p, mode, exp_mode[p]);
        miscompares++;
      end
      vectors++;
      if ({breath_en, breath_fast, led_force_on} !== exp_dec[p]) begin
        $display("FAIL short_decode[%0d]: got %b want %b", p,
                 {breath_en, breath_fast, led_force_on}, exp_dec[p]);
        miscompares++;
      end
      vectors++;
      if (key_flag_cnt - k0 != 1) begin
        $display("FAIL short_key_flag[%0d]: got %0d want 1", p, key_flag_cnt - k0);
        miscompares++;
      end
      edges(10);
    end
  endtask

  task automatic test_long_press;
    int l0;
    // Two short presses: OFF -> SLOW -> FAST.
    press_to_release(30);
    edges(11);
    press_to_release(30);
    edges(11);
    vectors++;
    if (mode !== 2'd2 || breath_fast !== 1'b1) begin
      $display("FAIL long_setup: mode=%0d breath_fast=%b want 2/1", mode, breath_fast);
      miscompares++;
    end
    l0 = long_flag_cnt;
    key_in = 1'b0;
    edges(51);
    vectors++;
    if (long_flag !== 1'b0 || mode !== 2'd2) begin
      $display("FAIL long_early: long_flag=%b mode=%0d want 0/2", long_flag, mode);
      miscompares++;
    end
    edges(1);
    vectors++;
    if (long_flag !== 1'b1 || mode !== 2'd0) begin
      $display("FAIL long_fire: long_flag=%b mode=%0d want 1/0", long_flag, mode);
      miscompares++;
    end
    edges(1);
    vectors++;
    if (long_flag !== 1'b0) begin
      $display("FAIL long_pulse_width: long_flag=%b want 0", long_flag);
      miscompares++;
    end
    edges(6);
    key_in = 1'b1;
    edges(30);
    vectors++;
    if (mode !== 2'd0) begin
      $display("FAIL long_release_mode: got %0d want 0", mode);
      miscompares++;
    end
    vectors++;
    if (long_flag_cnt - l0 != 1) begin
      $display("FAIL long_flag_count: got %0d want 1", long_flag_cnt - l0);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_press;
    int k0;
    press_to_release(30);
    edges(11);
    vectors++;
    if (mode !== 2'd1) begin
      $display("FAIL midrst_setup: got %0d want 1", mode);
      miscompares++;
    end
    key_in = 1'b0;
    edges(20);
    sys_rst = 1'b1;
    #1;
    vectors++;
    if (mode !== 2'd0 || breath_en !== 1'b0) begin
      $display("FAIL midrst_async: mode=%0d breath_en=%b want 0/0", mode, breath_en);
      miscompares++;
    end
    edges(3);
    k0 = key_flag_cnt;
    sys_rst = 1'b0;
    edges(5);
    key_in = 1'b1;
    edges(30);
    vectors++;
    if (mode !== 2'd0) begin
      $display("FAIL midrst_mode: got %0d want 0", mode);
      miscompares++;
    end
    vectors++;
    if (key_flag_cnt != k0) begin
      $display("FAIL midrst_key_flag: got %0d pulses want 0", key_flag_cnt - k0);
      miscompares++;
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    key_in  = 1'b1;
    @(negedge sys_clk);
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
